// File: rtl/branch_predict_ctrl_if.sv
// Fetch/EX handshake bundle between the pipeline and the branch prediction controller.
interface branch_predict_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // Fetch side
    logic              if_valid;
    logic              if_is_branch;
    logic [31:0]       if_pc;
    logic [31:0]       if_target;
    logic              pred_taken;
    logic [31:0]       next_pc;
    // EX side
    logic              stall;
    logic              ex_valid;
    logic [2:0]        ex_br_type;
    logic              ex_br_taken;
    logic              ex_pred_taken;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_target;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              flush_if_id;
    logic              flush_id_ex;
    // Statistics
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispredict_cnt;

    // Pipeline side: drives fetch/EX information, consumes predictions and redirects
    modport master (
        output if_valid, if_is_branch, if_pc, if_target,
        output stall, ex_valid, ex_br_type, ex_br_taken, ex_pred_taken, ex_pc, ex_target,
        input  pred_taken, next_pc, redirect, redirect_pc, flush_if_id, flush_id_ex,
        input  branch_cnt, mispredict_cnt
    );

    // Controller side
    modport slave (
        input  if_valid, if_is_branch, if_pc, if_target,
        input  stall, ex_valid, ex_br_type, ex_br_taken, ex_pred_taken, ex_pc, ex_target,
        output pred_taken, next_pc, redirect, redirect_pc, flush_if_id, flush_id_ex,
        output branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch predictor (direct-mapped 2-bit counters) and EX-side resolution/redirect sequencer.
module branch_predict_ctrl #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int unsigned Entries = 1 << IDX_W;
    // br_type encodings: BEQ..BGEU are 0..5
    localparam logic [2:0] BrPc  = 3'd6;
    localparam logic [2:0] BrAlu = 3'd7;

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [1:0]       bht_q [Entries];
    logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             is_cond, is_alu, ev, mispredict, need_redirect, train;
    logic [31:0]      correct_pc;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             pred_taken;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];

    // Prediction and next fetch PC; the table read sees the pre-update counter
    always_comb begin
        pred_taken = bus.if_valid & bus.if_is_branch & bht_q[if_idx][1];
        if (redirect) begin
            bus.next_pc = redirect_pc;
        end else if (pred_taken) begin
            bus.next_pc = bus.if_target;
        end else begin
            bus.next_pc = bus.if_pc + 32'd4;
        end
    end

    // Classify the EX instruction and decide whether it trains this edge
    always_comb begin
        is_cond       = bus.ex_br_type < BrPc;
        is_alu        = bus.ex_br_type == BrAlu;
        ev            = bus.ex_valid && (state_q == StIdle);
        mispredict    = bus.ex_br_taken != bus.ex_pred_taken;
        need_redirect = ev && (is_alu || (is_cond && mispredict));
        correct_pc    = (is_alu || bus.ex_br_taken) ? bus.ex_target : bus.ex_pc + 32'd4;
        // A correctly predicted branch under stall waits so it is trained only once;
        // a mispredict under stall trains now because PENDING ignores EX afterwards.
        train         = ev && is_cond && (!bus.stall || mispredict) && !rst;
    end

    // Redirect sequencing: issue immediately, or park the target until the stall clears
    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        redirect    = 1'b0;
        redirect_pc = correct_pc;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (need_redirect) begin
                        if (bus.stall) begin
                            pend_pc_d = correct_pc;
                            state_d   = StPending;
                        end else begin
                            redirect = 1'b1;
                        end
                    end
                end
                StPending: begin
                    redirect_pc = pend_pc_q;
                    if (!bus.stall) begin
                        redirect = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and pending-target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Counter table training and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                bht_q[i] <= 2'b01;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (train) begin
            if (bus.ex_br_taken && bht_q[ex_idx] != 2'b11) begin
                bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
            end else if (!bus.ex_br_taken && bht_q[ex_idx] != 2'b00) begin
                bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
            end
            branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pred_taken     = pred_taken;
    assign bus.redirect       = redirect;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.flush_if_id    = redirect;
    assign bus.flush_id_ex    = redirect;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed vector bench for branch_predict_ctrl.
module tb_branch_predict_ctrl;
    localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLT = 3'd2, BGE = 3'd3, PC = 3'd6, ALU = 3'd7;

    typedef struct {
        logic        iv, ib;
        logic [31:0] ipc, itg;
        logic        st, ev;
        logic [2:0]  ty;
        logic        tk, pt;
        logic [31:0] epc, etg;
        logic        e_pred;
        logic [31:0] e_next;
        logic        e_red;
        logic [31:0] e_rpc;
        int          e_bc, e_mc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [14];

    branch_predict_ctrl_if #(.CNT_W(16)) bus ();

    branch_predict_ctrl #(.IDX_W(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, ib, input logic [31:0] ipc, itg,
                                input logic st, ev, input logic [2:0] ty, input logic tk, pt,
                                input logic [31:0] epc, etg, input logic p,
                                input logic [31:0] np, input logic r, input logic [31:0] rpc,
                                input int bc, mc);
        vec_t v;
        v.iv = iv; v.ib = ib; v.ipc = ipc; v.itg = itg; v.st = st; v.ev = ev; v.ty = ty;
        v.tk = tk; v.pt = pt; v.epc = epc; v.etg = etg; v.e_pred = p; v.e_next = np;
        v.e_red = r; v.e_rpc = rpc; v.e_bc = bc; v.e_mc = mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_if(input logic iv, ib, input logic [31:0] pc, tg);
        bus.if_valid = iv; bus.if_is_branch = ib; bus.if_pc = pc; bus.if_target = tg;
    endtask

    task automatic set_ex(input logic st, ev, input logic [2:0] ty, input logic tk, pt,
                          input logic [31:0] pc, tg);
        bus.stall = st; bus.ex_valid = ev; bus.ex_br_type = ty; bus.ex_br_taken = tk;
        bus.ex_pred_taken = pt; bus.ex_pc = pc; bus.ex_target = tg;
    endtask

    task automatic chk_red(input string name, input logic r, input logic [31:0] rpc);
        chk({name, ".redirect"}, {31'd0, bus.redirect}, {31'd0, r});
        chk({name, ".flush_if_id"}, {31'd0, bus.flush_if_id}, {31'd0, r});
        chk({name, ".flush_id_ex"}, {31'd0, bus.flush_id_ex}, {31'd0, r});
        if (r) chk({name, ".redirect_pc"}, bus.redirect_pc, rpc);
    endtask

    task automatic chk_cnt(input string name, input int bc, mc);
        chk({name, ".branch_cnt"}, {16'd0, bus.branch_cnt}, bc[31:0]);
        chk({name, ".mispredict_cnt"}, {16'd0, bus.mispredict_cnt}, mc[31:0]);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: outputs observed before the edge; counters show pre-edge values
        vecs[0]  = mk(1, 1, 'h100, 'h140, 0, 0, BEQ, 0, 0, 0, 0, 0, 'h104, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 'h100, 'h140, 0, 1, BEQ, 1, 0, 'h100, 'h140,
                      0, 'h140, 1, 'h140, 0, 0);
        vecs[2]  = mk(1, 1, 'h100, 'h140, 0, 0, BEQ, 0, 0, 0, 0, 1, 'h140, 0, 0, 1, 1);
        vecs[3]  = mk(1, 1, 'h104, 'h180, 0, 1, BNE, 1, 1, 'h104, 'h180, 0, 'h108, 0, 0, 1, 1);
        vecs[4]  = mk(1, 1, 'h104, 'h180, 0, 1, BNE, 1, 1, 'h104, 'h180, 1, 'h180, 0, 0, 2, 1);
        vecs[5]  = mk(1, 1, 'h104, 'h180, 0, 1, BNE, 1, 1, 'h104, 'h180, 1, 'h180, 0, 0, 3, 1);
        vecs[6]  = mk(1, 1, 'h104, 'h180, 0, 1, BNE, 1, 1, 'h104, 'h180, 1, 'h180, 0, 0, 4, 1);
        vecs[7]  = mk(1, 1, 'h104, 'h180, 0, 1, BNE, 0, 1, 'h104, 'h180,
                      1, 'h108, 1, 'h108, 5, 1);
        vecs[8]  = mk(1, 1, 'h104, 'h180, 0, 0, BEQ, 0, 0, 0, 0, 1, 'h180, 0, 0, 6, 2);
        vecs[9]  = mk(0, 0, 'h200, 0, 0, 1, ALU, 0, 0, 'h308, 'h2000,
                      0, 'h2000, 1, 'h2000, 6, 2);
        vecs[10] = mk(0, 0, 'h200, 0, 0, 1, PC, 0, 0, 'h308, 'h3000, 0, 'h204, 0, 0, 6, 2);
        vecs[11] = mk(1, 1, 'h308, 'h400, 0, 0, BEQ, 0, 0, 0, 0, 0, 'h30c, 0, 0, 6, 2);
        vecs[12] = mk(1, 1, 'h140, 'h1c0, 0, 0, BEQ, 0, 0, 0, 0, 1, 'h1c0, 0, 0, 6, 2);
        vecs[13] = mk(0, 1, 'h100, 'h140, 0, 0, BEQ, 0, 0, 0, 0, 0, 'h104, 0, 0, 6, 2);

        // Reset with a mispredict presented: nothing may be issued
        rst = 1'b1;
        set_if(0, 0, 0, 0);
        set_ex(0, 1, BEQ, 1, 0, 'h100, 'h140);
        next_cycle();
        #4 chk_red("reset", 0, 0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            set_if(vecs[i].iv, vecs[i].ib, vecs[i].ipc, vecs[i].itg);
            set_ex(vecs[i].st, vecs[i].ev, vecs[i].ty, vecs[i].tk, vecs[i].pt,
                   vecs[i].epc, vecs[i].etg);
            #4;
            chk({nm, ".pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, vecs[i].e_pred});
            chk({nm, ".next_pc"}, bus.next_pc, vecs[i].e_next);
            chk_red(nm, vecs[i].e_red, vecs[i].e_rpc);
            chk_cnt(nm, vecs[i].e_bc, vecs[i].e_mc);
            next_cycle();
        end

        // Mispredict under a 3-cycle stall, EX inputs changed mid-stall
        set_if(0, 0, 'h0, 'h0);
        set_ex(1, 1, BLT, 1, 0, 'h10c, 'h200);
        #4 chk_red("stall_c1", 0, 0);
        next_cycle();
        set_ex(1, 1, BEQ, 0, 1, 'h500, 'h600);
        #4 chk_red("stall_c2", 0, 0);
        chk_cnt("stall_c2", 7, 3);
        next_cycle();
        #4 chk_red("stall_c3", 0, 0);
        next_cycle();
        set_ex(0, 1, BEQ, 0, 1, 'h500, 'h600);
        #4 chk_red("stall_rel", 1, 'h200);
        chk("stall_rel.next_pc", bus.next_pc, 32'h200);
        next_cycle();
        set_ex(0, 0, BEQ, 0, 0, 0, 0);
        #4 chk_red("stall_after", 0, 0);
        chk_cnt("stall_after", 7, 3);
        next_cycle();
        // One not-taken step: 10 -> 01 if trained once during the stall
        set_ex(0, 1, BLT, 0, 0, 'h10c, 'h200);
        #4 chk_red("idx3_nt", 0, 0);
        next_cycle();
        set_ex(0, 0, BEQ, 0, 0, 0, 0);
        set_if(1, 1, 'h10c, 'h250);
        #4 chk("idx3_pred", {31'd0, bus.pred_taken}, 32'd0);
        chk("idx3_next", bus.next_pc, 32'h110);
        chk_cnt("idx3", 8, 3);
        next_cycle();

        // Correctly predicted branch held by a stall trains exactly once
        set_if(0, 0, 0, 0);
        set_ex(1, 1, BGE, 1, 1, 'h110, 'h400);
        #4 chk_red("cstall_c1", 0, 0);
        next_cycle();
        #4 chk_cnt("cstall_c2", 8, 3);
        next_cycle();
        set_ex(0, 1, BGE, 1, 1, 'h110, 'h400);
        #4 chk_red("cstall_rel", 0, 0);
        next_cycle();
        set_ex(0, 0, BEQ, 0, 0, 0, 0);
        set_if(1, 1, 'h110, 'h400);
        #4 chk("cstall_pred", {31'd0, bus.pred_taken}, 32'd1);
        chk("cstall_next", bus.next_pc, 32'h400);
        chk_cnt("cstall", 9, 3);
        next_cycle();

        // Reset while PENDING drops the parked redirect
        set_if(0, 0, 0, 0);
        set_ex(1, 1, BEQ, 0, 1, 'h100, 'h140);
        #4 chk_red("rstpend_cap", 0, 0);
        next_cycle();
        rst = 1'b1;
        set_ex(0, 0, BEQ, 0, 0, 0, 0);
        #4 chk_red("rstpend_rst", 0, 0);
        next_cycle();
        rst = 1'b0;
        set_if(1, 1, 'h100, 'h140);
        #4 chk_red("rstpend_after", 0, 0);
        chk("rstpend_pred", {31'd0, bus.pred_taken}, 32'd0);
        chk_cnt("rstpend", 0, 0);
        next_cycle();
        #4 chk_red("rstpend_after2", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Fetch-side branch prediction and EX-side resolution controller for the pipelined RV32I core. It predicts conditional branches with a direct-mapped table of 2-bit saturating counters. It consumes the branch comparator's br_taken result in EX, trains the table, and sequences PC redirect and pipeline flushes. Mispredicts that occur during a pipeline stall are held and issued once the stall clears.

Parameters:
IDX_W, 4, BHT index width; table holds 2**IDX_W counters
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch slot holds a valid instruction
if_is_branch  in  1  predecode: conditional branch (BEQ..BGEU)
if_pc  in  32  fetch PC
if_target  in  32  predecoded target (if_pc + B-imm)
pred_taken  out  1  prediction for the current fetch
next_pc  out  32  next fetch PC
stall  in  1  pipeline freeze; EX inputs are held stable while high
ex_valid  in  1  EX slot valid
ex_br_type  in  3  br_type from the shared packages enum (BEQ,BNE,BLT,BGE,BLTU,BGEU,PC,ALU)
ex_br_taken  in  1  comparator result for the EX instruction
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pc  in  32  PC of the EX instruction
ex_target  in  32  resolved target (branch target or jump/ALU address)
redirect  out  1  override next_pc with redirect_pc this cycle
redirect_pc  out  32  corrected fetch PC
flush_if_id  out  1  kill IF/ID contents
flush_id_ex  out  1  kill ID/EX contents
branch_cnt  out  CNT_W  resolved conditional branches
mispredict_cnt  out  CNT_W  conditional-branch mispredicts

Behaviour:
- Reset (synchronous): all counters set to 2'b01 (weakly not-taken), FSM to IDLE, pending registers cleared, branch_cnt and mispredict_cnt set to 0. During reset, redirect, flush_if_id and flush_id_ex are 0.
- Index: idx = pc[IDX_W+1:2]. No tags, so aliasing is allowed.
- Prediction (combinational): pred_taken = if_valid & if_is_branch & bht[if_idx][1].
- next_pc priority: redirect_pc if redirect; else if_target if pred_taken; else if_pc+4. All adds are mod 2^32.
- Resolution event: ex_valid=1 and FSM=IDLE. Classes:
  - Conditional (BEQ..BGEU):
    - mispredict = ex_br_taken != ex_pred_taken.
    - correct PC = ex_br_taken ? ex_target : ex_pc+4.
    - Counter saturating update: +1 if taken (max 11), -1 if not taken (min 00).
    - branch_cnt +1; mispredict_cnt +1 on mispredict.
  - ALU (jal/jalr): always redirect to ex_target. No training, no counting.
  - PC, or any other encoding: no action.
- FSM states IDLE, PENDING.
  - IDLE, event needs redirect, stall=0: redirect=1, redirect_pc=correct PC, flush_if_id=1, flush_id_ex=1, all in the same cycle. Training and counters update at the next edge. Remain in IDLE.
  - IDLE, event needs redirect, stall=1: capture redirect_pc into a pending register and go to PENDING. redirect and flushes stay 0. Training and counters update exactly once, at this edge.
  - IDLE, conditional branch predicted correctly, stall=1: no training until stall=0, so it is trained exactly once.
  - PENDING, stall=1: hold. Outputs stay 0. EX inputs are ignored.
  - PENDING, stall=0: redirect=1 with the captured PC, both flushes=1 for exactly one cycle, then return to IDLE. EX inputs are ignored that cycle.
- Same-cycle read/update of the same index: the prediction uses the pre-update counter value.
- Counters wrap at 2^CNT_W.
- rst while PENDING: pending redirect is dropped, no redirect is issued, FSM goes to IDLE.

Test Plan:
- Reset, then fetch BEQ at 0x100 (if_target 0x140) -> pred_taken=0, next_pc=0x104, redirect=0, both cnts=0.
- EX BEQ at 0x100, ex_br_taken=1, ex_pred_taken=0, ex_target=0x140, stall=0 -> redirect=1, redirect_pc=0x140, both flushes=1 for 1 cycle, bht[0]=10, branch_cnt=1, mispredict_cnt=1. Refetch of 0x100 -> pred_taken=1, next_pc=0x140.
- Four taken BNE resolutions at 0x104 -> bht[1] saturates at 11. One not-taken (ex_pred_taken=1, ex_pc=0x104) -> redirect_pc=0x108, bht[1]=10, prediction still taken.
- Mispredict with stall=1 for 3 cycles, EX inputs changed on cycle 2 -> redirect=0 during the stall, counter trained once. On the first stall=0 cycle, single-cycle redirect with the originally captured PC. mispredict_cnt +1 only.
- ALU type, ex_target=0x2000 -> redirect to 0x2000, flushes=1, no bht or counter change. PC type -> no outputs asserted.
- Aliasing: train 0x100 taken, then fetch a branch at 0x140 (same idx 0) -> pred_taken=1. Also: rst asserted while PENDING -> no redirect after reset, FSM IDLE.
